axi_revision_reader: RTL
========================

Name: axi_revision_reader

Overview:
- AXI4-Lite read-only master that sits directly upstream of the build-revision slave and consumes what that slave produces.
- On a start pulse, it reads the seven revision registers (major, minor, build, release candidate, date, RTL type, RTL subtype) at BASE_ADDR + 0x00..0x18.
- It latches each value and presents all of them as parallel outputs with done/error status.
- Used by local health and identity logic that must know the RTL identity without CPU involvement.

Parameters:
- M_AXI_ADDR_WIDTH, 32, width of ARADDR.
- M_AXI_DATA_WIDTH, 32, width of RDATA; fixed at 32 for this block.
- BASE_ADDR, 0, byte address of the revision slave's register 0.
- TIMEOUT_CYCLES, 1024, watchdog limit per AR or R phase; used only when the optional feature is compiled in.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- AXI_ACLK  in  1  sole clock; everything is rising-edge.
- AXI_ARESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a read sweep.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start or reset.
- error  out  1  valid with done; set if any RRESP != OKAY or a timeout occurred.
- rev_major, rev_minor, rev_build, rev_rcand  out  32 each  captured registers 0..3.
- rev_month  out  8  captured date[31:24].
- rev_day  out  8  captured date[23:16].
- rev_year  out  16  captured date[15:0].
- rtl_type, rtl_subtype  out  32 each  captured registers 5 and 6.
- M_AXI_ARADDR  out  M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RREADY  out  1  read data ready.
- No write channels are present.

Behaviour:
- Reset (asynchronous): state=IDLE, index=0, ARVALID=0, RREADY=0, busy=0, done=0, error=0, all captured fields=0, ARADDR=BASE_ADDR.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on start, set index=0, ARADDR=BASE_ADDR, ARVALID=1, busy=1, done=0, error=0, then go to ADDR.
- ADDR: hold ARVALID and ARADDR stable until ARVALID&ARREADY. On that cycle: ARVALID<=0, RREADY<=1, go to DATA.
- DATA: wait for RVALID&RREADY. On that cycle: RREADY<=0, store RDATA into the field selected by index.
  - If RRESP != 0: set error (sticky for the sweep) and store 0 instead of RDATA.
  - If index==6: go to DONE with busy<=0, done<=1.
  - Otherwise: index<=index+1, ARADDR<=BASE_ADDR+4*(index+1), ARVALID<=1, go to ADDR.
- DONE: outputs hold. A start restarts the sweep exactly as from IDLE; captured fields keep old values until overwritten.
- Only one outstanding transaction at any time. ARADDR is registered; no combinational path from any input to any AXI output.
- Latency: with a zero-wait slave (ARREADY=1, RVALID the cycle after the AR handshake), each register takes 2 cycles, so done rises 14 cycles after start.
- start while busy is ignored, with no effect on the sweep.
- Fields update only at their own R handshake; no partial or mixed-width writes.
- Reset mid-sweep: ARVALID and RREADY drop immediately, and all outputs return to their reset values.

Optional Feature:
- Macro: AXI_REV_READER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ADDR or DATA and increments each cycle spent in that state.
  - When it reaches TIMEOUT_CYCLES: drop ARVALID/RREADY, set error=1, go to DONE with done=1. Fields not yet read stay 0.
  - An extra output timeout (1 bit) is added; it is cleared on start or reset.
- Not defined: no counter and no timeout port; a hung slave leaves busy=1 forever.

Decomposition:
- Package axi_rev_pkg holds:
  - register index constants REG_MAJOR=0 .. REG_RTL_SUBTYPE=6 and REG_COUNT=7;
  - OKAY=2'b00 and SLVERR=2'b10;
  - the state enum IDLE/ADDR/DATA/DONE;
  - the date bit-slice constants.
- No sub-module: a single FSM with a 3-bit index is natural. The timeout counter stays inline under the macro.

Test Plan:
- Slave model returns 0x10+index with zero wait, start pulsed -> ARADDR sequence BASE_ADDR+0x00..0x18; rev_major=0x10 ... rtl_subtype=0x16; done rises exactly 14 cycles after start; error=0.
- Date register returns 0x0C1B07E8 -> rev_month=0x0C, rev_day=0x1B, rev_year=0x07E8.
- Slave holds ARREADY low for 5 cycles and delays RVALID by 3 cycles per read -> ARVALID/ARADDR stable while stalled; all 7 values captured correctly.
- RRESP=SLVERR on index 2 only -> rev_build=0, error=1 at done, other six fields correct.
- Reset asserted while in DATA at index 3 -> ARVALID=RREADY=busy=done=0 at once. A new start after release reads all 7 registers.
- Macro defined, TIMEOUT_CYCLES=16, slave never returns RVALID -> done=1, error=1, timeout=1 after 16 cycles in DATA; a following start clears timeout.

Source files
------------

// File: rtl/axi_rev_pkg.sv
// Shared definitions for the AXI4-Lite revision reader.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package axi_rev_pkg;

    // Register indices within the revision slave (word offsets).
    localparam logic [2:0] REG_MAJOR       = 3'd0;
    localparam logic [2:0] REG_MINOR       = 3'd1;
    localparam logic [2:0] REG_BUILD       = 3'd2;
    localparam logic [2:0] REG_RCAND       = 3'd3;
    localparam logic [2:0] REG_DATE        = 3'd4;
    localparam logic [2:0] REG_RTL_TYPE    = 3'd5;
    localparam logic [2:0] REG_RTL_SUBTYPE = 3'd6;
    localparam int         REG_COUNT       = 7;

    // AXI read responses of interest.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Date register layout: month | day | year.
    localparam int DATE_MONTH_MSB = 31;
    localparam int DATE_MONTH_LSB = 24;
    localparam int DATE_DAY_MSB   = 23;
    localparam int DATE_DAY_LSB   = 16;
    localparam int DATE_YEAR_MSB  = 15;
    localparam int DATE_YEAR_LSB  = 0;

    // Byte offset of a register index (32-bit registers).
    function automatic logic [4:0] reg_offset(input logic [2:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/axi_revision_reader.sv
// AXI4-Lite read-only master: on start, sweeps the 7 revision registers at BASE_ADDR+0x00..0x18 and latches them.
// Latency: 2 cycles per register with a zero-wait slave; done rises 14 cycles after start is sampled.
// Backpressure: one outstanding read; ARVALID/ARADDR held until ARREADY, RREADY held until RVALID.
//
// Ports: AXI_ACLK/AXI_ARESET (async, active-high); start/busy/done/error sweep control and status;
//        rev_* / rtl_* captured fields; M_AXI_AR* / M_AXI_R* read-only AXI4-Lite master channels.
// Optional: define AXI_REV_READER_TIMEOUT_EN to add a per-phase watchdog and the timeout output.
module axi_revision_reader
    import axi_rev_pkg::*;
#(
    parameter int                          M_AXI_ADDR_WIDTH = 32,
    parameter int                          M_AXI_DATA_WIDTH = 32,
    parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int unsigned                 TIMEOUT_CYCLES   = 1024
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
`ifdef AXI_REV_READER_TIMEOUT_EN
    output logic                        timeout,
`endif
    output logic [31:0]                 rev_major,
    output logic [31:0]                 rev_minor,
    output logic [31:0]                 rev_build,
    output logic [31:0]                 rev_rcand,
    output logic [7:0]                  rev_month,
    output logic [7:0]                  rev_day,
    output logic [15:0]                 rev_year,
    output logic [31:0]                 rtl_type,
    output logic [31:0]                 rtl_subtype,
    output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_ARREADY,
    input  logic [31:0]                 M_AXI_RDATA,
    input  logic                        M_AXI_RVALID,
    input  logic [1:0]                  M_AXI_RRESP,
    output logic                        M_AXI_RREADY
);

    // The field registers are 32 bits wide; a zero watchdog limit is meaningless.
    if (M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("axi_revision_reader: M_AXI_DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
    end

    state_t                      r_state,   w_state_nxt;
    logic [2:0]                  r_index,   w_index_nxt;
    logic [M_AXI_ADDR_WIDTH-1:0] r_araddr,  w_araddr_nxt;
    logic                        r_arvalid, w_arvalid_nxt;
    logic                        r_rready,  w_rready_nxt;
    logic                        r_busy,    w_busy_nxt;
    logic                        r_done,    w_done_nxt;
    logic                        r_error,   w_error_nxt;
    logic [31:0]                 r_fields     [REG_COUNT];
    logic [31:0]                 w_fields_nxt [REG_COUNT];

    logic                        w_ar_fire;
    logic                        w_r_fire;
    logic [2:0]                  w_index_inc;

`ifdef AXI_REV_READER_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] r_tcnt,    w_tcnt_nxt;
    logic           r_timeout, w_timeout_nxt;
`endif

    assign w_ar_fire   = r_arvalid && M_AXI_ARREADY;
    assign w_r_fire    = r_rready && M_AXI_RVALID;
    assign w_index_inc = r_index + 3'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_araddr_nxt  = r_araddr;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_error_nxt   = r_error;
        w_fields_nxt  = r_fields;
`ifdef AXI_REV_READER_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
        w_timeout_nxt = r_timeout;
`endif

        unique case (r_state)
            // DONE accepts a new start exactly like IDLE; fields are kept until overwritten.
            IDLE, DONE: begin
                if (start) begin
                    w_index_nxt   = REG_MAJOR;
                    w_araddr_nxt  = BASE_ADDR;
                    w_arvalid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
`ifdef AXI_REV_READER_TIMEOUT_EN
                    w_timeout_nxt = 1'b0;
`endif
                    w_state_nxt   = ADDR;
                end
            end
            ADDR: begin
                if (w_ar_fire) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                if (w_r_fire) begin
                    w_rready_nxt = 1'b0;
                    // An errored response stores 0 so a bad read never looks like a valid identity.
                    for (int i = 0; i < REG_COUNT; i++) begin
                        if (r_index == 3'(i)) begin
                            w_fields_nxt[i] = (M_AXI_RRESP == OKAY) ? M_AXI_RDATA : 32'd0;
                        end
                    end
                    if (M_AXI_RRESP != OKAY) begin
                        w_error_nxt = 1'b1;
                    end
                    if (r_index == REG_RTL_SUBTYPE) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_index_nxt   = w_index_inc;
                        w_araddr_nxt  = BASE_ADDR + M_AXI_ADDR_WIDTH'(reg_offset(w_index_inc));
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ADDR;
                    end
                end
            end
            default: ;
        endcase

`ifdef AXI_REV_READER_TIMEOUT_EN
        // Counter restarts on every state change, so each AR or R phase gets its own budget.
        if (w_state_nxt != r_state) begin
            w_tcnt_nxt = '0;
        end else if (r_state == ADDR || r_state == DATA) begin
            if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
                w_error_nxt   = 1'b1;
                w_timeout_nxt = 1'b1;
                w_tcnt_nxt    = '0;
                w_state_nxt   = DONE;
            end else begin
                w_tcnt_nxt = r_tcnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_state   <= IDLE;
            r_index   <= REG_MAJOR;
            r_araddr  <= BASE_ADDR;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_fields[i] <= 32'd0;
            end
`ifdef AXI_REV_READER_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_araddr  <= w_araddr_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_fields  <= w_fields_nxt;
`ifdef AXI_REV_READER_TIMEOUT_EN
            r_tcnt    <= w_tcnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
`ifdef AXI_REV_READER_TIMEOUT_EN
    assign timeout       = r_timeout;
`endif
    assign rev_major     = r_fields[REG_MAJOR];
    assign rev_minor     = r_fields[REG_MINOR];
    assign rev_build     = r_fields[REG_BUILD];
    assign rev_rcand     = r_fields[REG_RCAND];
    assign rev_month     = r_fields[REG_DATE][DATE_MONTH_MSB:DATE_MONTH_LSB];
    assign rev_day       = r_fields[REG_DATE][DATE_DAY_MSB:DATE_DAY_LSB];
    assign rev_year      = r_fields[REG_DATE][DATE_YEAR_MSB:DATE_YEAR_LSB];
    assign rtl_type      = r_fields[REG_RTL_TYPE];
    assign rtl_subtype   = r_fields[REG_RTL_SUBTYPE];
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = r_rready;

endmodule
